// File: rtl/accum_seq_pkg.sv
// rtl/accum_seq_pkg.sv - shared state encoding, width helpers and hazard constant for the tag sequencer
package accum_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Idle cycles the accumulator needs between two beats to the same pixel_idx.
  localparam int HAZARD_BUBBLE = 1;

  function automatic int pix_w(input int max_width);
    return (max_width > 1) ? $clog2(max_width) : 1;
  endfunction

  function automatic int tile_w(input int max_ch_tiles);
    return (max_ch_tiles > 1) ? $clog2(max_ch_tiles) : 1;
  endfunction

endpackage

// File: rtl/accum_seq_counter.sv
// rtl/accum_seq_counter.sv - nested pixel (inner) / channel-tile (outer) counter with first/last flags
module accum_seq_counter
  import accum_seq_pkg::*;
#(
  parameter int PIX_W  = pix_w(512),
  parameter int TILE_W = tile_w(64)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [PIX_W-1:0]  i_last_pixel,
  input  logic [TILE_W-1:0] i_last_tile,
  output logic [PIX_W-1:0]  o_pix,
  output logic [TILE_W-1:0] o_tile,
  output logic              o_is_first,
  output logic              o_is_last,
  output logic              o_pass_end
);

  logic [PIX_W-1:0]  r_pix;
  logic [TILE_W-1:0] r_tile;
  logic              w_pix_wrap;

  assign w_pix_wrap = (r_pix == i_last_pixel);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_pix  <= '0;
      r_tile <= '0;
    end else if (i_advance) begin
      if (w_pix_wrap) begin
        r_pix  <= '0;
        r_tile <= r_tile + 1'b1;
      end else begin
        r_pix <= r_pix + 1'b1;
      end
    end
  end

  assign o_pix      = r_pix;
  assign o_tile     = r_tile;
  assign o_is_first = (r_tile == '0);
  assign o_is_last  = (r_tile == i_last_tile);
  assign o_pass_end = w_pix_wrap && o_is_last;

endmodule

// File: rtl/accum_tag_sequencer.sv
// rtl/accum_tag_sequencer.sv - tags conv beats with pixel/channel-tile info for the partial-sum accumulator
// Optional ACC_SEQ_ERR_FLAG_EN adds the err_sticky protocol-error output.
module accum_tag_sequencer
  import accum_seq_pkg::*;
#(
  parameter int MAX_WIDTH    = 512,
  parameter int MAX_CH_TILES = 64,
  parameter int DATA_W       = 32,
  parameter int PIX_W        = pix_w(MAX_WIDTH),
  parameter int TILE_W       = tile_w(MAX_CH_TILES)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ACC_SEQ_ERR_FLAG_EN
  output logic              err_sticky,
`endif
  input  logic [PIX_W-1:0]  cfg_last_pixel,
  input  logic [TILE_W-1:0] cfg_last_tile,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] conv_data_in,
  input  logic              conv_valid_in,
  output logic              conv_ready_out,
  output logic [DATA_W-1:0] acc_data,
  output logic              acc_valid,
  output logic              acc_is_first,
  output logic              acc_is_last,
  output logic [PIX_W-1:0]  acc_pixel_idx
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_FLUSH = FLUSH;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [TILE_W-1:0] LAST_TILE_MAX = TILE_W'(MAX_CH_TILES - 1);
  localparam bit                TILE_POW2     = (MAX_CH_TILES == (1 << TILE_W));
  localparam logic [1:0]        BUBBLE_LEN    = 2'(HAZARD_BUBBLE);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [PIX_W-1:0]  r_last_pixel;
  logic [TILE_W-1:0] r_last_tile;
  logic [1:0]        r_bubble_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_acc_valid;
  logic [DATA_W-1:0] r_acc_data;
  logic              r_acc_first;
  logic              r_acc_last;
  logic [PIX_W-1:0]  r_acc_pix;

  logic              w_cfg_reject;
  logic              w_start_ok;
  logic              w_accept;
  logic [PIX_W-1:0]  w_pix;
  logic [TILE_W-1:0] w_tile;
  logic              w_is_first;
  logic              w_is_last;
  logic              w_pass_end;

  // A tile limit beyond MAX_CH_TILES is only encodable when the count is not a power of two.
  assign w_cfg_reject   = !TILE_POW2 && (cfg_last_tile > LAST_TILE_MAX);
  assign w_start_ok     = start && (r_state == ST_IDLE) && !w_cfg_reject;
  assign conv_ready_out = (r_state == ST_RUN) && (r_bubble_cnt == 2'd0);
  assign w_accept       = conv_valid_in && conv_ready_out;

  accum_seq_counter #(
    .PIX_W  (PIX_W),
    .TILE_W (TILE_W)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_ok),
    .i_advance    (w_accept),
    .i_last_pixel (r_last_pixel),
    .i_last_tile  (r_last_tile),
    .o_pix        (w_pix),
    .o_tile       (w_tile),
    .o_is_first   (w_is_first),
    .o_is_last    (w_is_last),
    .o_pass_end   (w_pass_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && w_pass_end) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_pixel <= '0;
      r_last_tile  <= '0;
      r_bubble_cnt <= 2'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_acc_data   <= '0;
      r_acc_first  <= 1'b0;
      r_acc_last   <= 1'b0;
      r_acc_pix    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FLUSH);
      r_done      <= (w_state_nxt == ST_DONE);
      r_acc_valid <= w_accept;
      if (w_start_ok) begin
        r_last_pixel <= cfg_last_pixel;
        r_last_tile  <= cfg_last_tile;
      end
      // Single-pixel rows revisit the same pixel_idx on every beat, so insert the RMW gap.
      if (w_start_ok) begin
        r_bubble_cnt <= 2'd0;
      end else if (w_accept && (r_last_pixel == '0)) begin
        r_bubble_cnt <= BUBBLE_LEN;
      end else if (r_bubble_cnt != 2'd0) begin
        r_bubble_cnt <= r_bubble_cnt - 2'd1;
      end
      if (w_accept) begin
        r_acc_data  <= conv_data_in;
        r_acc_pix   <= w_pix;
        r_acc_first <= w_is_first;
        r_acc_last  <= w_is_last;
      end
    end
  end

`ifdef ACC_SEQ_ERR_FLAG_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((start && (r_state != ST_IDLE)) ||
                 (start && (r_state == ST_IDLE) && w_cfg_reject) ||
                 (conv_valid_in && (r_state == ST_IDLE))) begin
      r_err <= 1'b1;
    end
  end

  assign err_sticky = r_err;
`endif

  assign busy          = r_busy;
  assign done          = r_done;
  assign acc_valid     = r_acc_valid;
  assign acc_data      = r_acc_data;
  assign acc_is_first  = r_acc_first;
  assign acc_is_last   = r_acc_last;
  assign acc_pixel_idx = r_acc_pix;

endmodule

// File: tb/tb_accum_tag_sequencer.sv
// tb/tb_accum_tag_sequencer.sv - directed self-checking bench for accum_tag_sequencer
module tb_accum_tag_sequencer;

  localparam int DATA_W = 32;
  localparam int PIX_W  = 9;
  localparam int TILE_W = 6;
  localparam int VW     = 1 + DATA_W + PIX_W + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [PIX_W-1:0]  cfg_last_pixel;
  logic [TILE_W-1:0] cfg_last_tile;
  logic              start;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] conv_data_in;
  logic              conv_valid_in;
  logic              conv_ready_out;
  logic [DATA_W-1:0] acc_data;
  logic              acc_valid;
  logic              acc_is_first;
  logic              acc_is_last;
  logic [PIX_W-1:0]  acc_pixel_idx;
`ifdef ACC_SEQ_ERR_FLAG_EN
  logic              err_sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  accum_tag_sequencer #(
    .MAX_WIDTH    (512),
    .MAX_CH_TILES (64),
    .DATA_W       (DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef ACC_SEQ_ERR_FLAG_EN
    .err_sticky     (err_sticky),
`endif
    .cfg_last_pixel (cfg_last_pixel),
    .cfg_last_tile  (cfg_last_tile),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .conv_data_in   (conv_data_in),
    .conv_valid_in  (conv_valid_in),
    .conv_ready_out (conv_ready_out),
    .acc_data       (acc_data),
    .acc_valid      (acc_valid),
    .acc_is_first   (acc_is_first),
    .acc_is_last    (acc_is_last),
    .acc_pixel_idx  (acc_pixel_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int lp, input int lt);
    cfg_last_pixel = PIX_W'(lp);
    cfg_last_tile  = TILE_W'(lt);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; conv_valid_in = 1'b0; conv_data_in = '0;
    cfg_last_pixel = '0; cfg_last_tile = '0;
    repeat (3) step();
    n_tests++;
    if ({busy, done, conv_ready_out, acc_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, conv_ready_out, acc_valid});
    end
    n_tests++;
    if ({acc_data, acc_pixel_idx, acc_is_first, acc_is_last} !== '0) begin
      n_fail++; $display("FAIL reset_acc got data=%h idx=%0d f=%b l=%b exp all 0", acc_data, acc_pixel_idx, acc_is_first, acc_is_last);
    end
`ifdef ACC_SEQ_ERR_FLAG_EN
    n_tests++;
    if (err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got=%b exp=0", err_sticky);
    end
`endif
    rst = 1'b0;
    step();
    n_tests++;
    if ({busy, conv_ready_out, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle got=%b exp=000", {busy, conv_ready_out, done});
    end
  endtask

  task automatic test_row4();
    logic [VW-1:0] got, exp;
    start_pass(3, 2);
    n_tests++;
    if ({busy, conv_ready_out} !== 2'b11) begin
      n_fail++; $display("FAIL row4_start got=%b exp=11", {busy, conv_ready_out});
    end
    for (int k = 1; k <= 12; k++) begin
      conv_data_in = DATA_W'(k); conv_valid_in = 1'b1;
      n_tests++;
      if (conv_ready_out !== 1'b1) begin
        n_fail++; $display("FAIL row4_ready k=%0d got=%b exp=1", k, conv_ready_out);
      end
      step();
      got = {acc_valid, acc_data, acc_pixel_idx, acc_is_first, acc_is_last};
      exp = {1'b1, DATA_W'(k), PIX_W'((k - 1) % 4), (k <= 4), (k >= 9)};
      n_tests++;
      if (got !== exp || done !== 1'b0) begin
        n_fail++; $display("FAIL row4_beat k=%0d got=%h done=%b exp=%h done=0", k, got, done, exp);
      end
    end
    conv_valid_in = 1'b0;
    n_tests++;
    if ({busy, conv_ready_out, done} !== 3'b100) begin
      n_fail++; $display("FAIL row4_flush got=%b exp=100", {busy, conv_ready_out, done});
    end
    step();
    n_tests++;
    if ({done, busy, acc_valid} !== 3'b100 || acc_data !== 32'd12) begin
      n_fail++; $display("FAIL row4_done got=%b data=%0d exp=100 data=12", {done, busy, acc_valid}, acc_data);
    end
    step();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL row4_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_width1();
    logic [VW-1:0] got, exp;
    int beat = 0;
    start_pass(0, 3);
    for (int c = 0; c < 8; c++) begin
      conv_valid_in = 1'b1; conv_data_in = DATA_W'(100 + c);
      n_tests++;
      if (conv_ready_out !== ((c % 2) == 0)) begin
        n_fail++; $display("FAIL w1_ready c=%0d got=%b exp=%b", c, conv_ready_out, ((c % 2) == 0));
      end
      step();
      if ((c % 2) == 0) beat++;
      exp = {((c % 2) == 0), DATA_W'(100 + c - (c % 2)), PIX_W'(0), (beat == 1), (beat == 4)};
      got = {acc_valid, acc_data, acc_pixel_idx, acc_is_first, acc_is_last};
      n_tests++;
      if (got !== exp || done !== (c == 7)) begin
        n_fail++; $display("FAIL w1_beat c=%0d got=%h done=%b exp=%h done=%b", c, got, done, exp, (c == 7));
      end
    end
    conv_valid_in = 1'b0;
    step();
    n_tests++;
    if ({busy, done, acc_valid} !== 3'b000) begin
      n_fail++; $display("FAIL w1_end got=%b exp=000", {busy, done, acc_valid});
    end
  endtask

  task automatic test_one_tile();
    logic [VW-1:0] got, exp;
    start_pass(2, 0);
    for (int k = 1; k <= 3; k++) begin
      conv_valid_in = 1'b1; conv_data_in = DATA_W'(200 + k);
      step();
      got = {acc_valid, acc_data, acc_pixel_idx, acc_is_first, acc_is_last};
      exp = {1'b1, DATA_W'(200 + k), PIX_W'(k - 1), 1'b1, 1'b1};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL one_tile_beat k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    conv_valid_in = 1'b0;
    step();
    n_tests++;
    if ({done, busy, acc_valid} !== 3'b100) begin
      n_fail++; $display("FAIL one_tile_done got=%b exp=100", {done, busy, acc_valid});
    end
    step();
  endtask

  task automatic test_gapped();
    logic [VW-1:0] got, exp;
    int beat = 0;
    logic [DATA_W-1:0] exp_data = '0;
    start_pass(1, 1);
    for (int c = 0; c <= 10; c++) begin
      conv_valid_in = ((c % 3) == 0); conv_data_in = DATA_W'(50 + c);
      n_tests++;
      if (conv_ready_out !== (c <= 9)) begin
        n_fail++; $display("FAIL gap_ready c=%0d got=%b exp=%b", c, conv_ready_out, (c <= 9));
      end
      step();
      if ((c % 3) == 0) begin
        beat++; exp_data = DATA_W'(50 + c);
      end
      exp = {((c % 3) == 0), exp_data, PIX_W'((beat - 1) % 2), (beat <= 2), (beat >= 3)};
      got = {acc_valid, acc_data, acc_pixel_idx, acc_is_first, acc_is_last};
      n_tests++;
      if (got !== exp || done !== (c == 10)) begin
        n_fail++; $display("FAIL gap_beat c=%0d got=%h done=%b exp=%h done=%b", c, got, done, exp, (c == 10));
      end
    end
    conv_valid_in = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got, exp;
    start_pass(7, 0);
    for (int k = 1; k <= 5; k++) begin
      conv_valid_in = 1'b1; conv_data_in = DATA_W'(300 + k);
      step();
    end
    n_tests++;
    if ({acc_valid, acc_pixel_idx} !== {1'b1, PIX_W'(4)}) begin
      n_fail++; $display("FAIL rmid_pre got v=%b idx=%0d exp v=1 idx=4", acc_valid, acc_pixel_idx);
    end
    conv_valid_in = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({busy, done, conv_ready_out, acc_valid, acc_data, acc_pixel_idx, acc_is_first, acc_is_last} !== '0) begin
      n_fail++; $display("FAIL rmid_clear got b=%b d=%b r=%b v=%b data=%h idx=%0d exp all 0", busy, done, conv_ready_out, acc_valid, acc_data, acc_pixel_idx);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if ({done, acc_valid, busy} !== 3'b000) begin
        n_fail++; $display("FAIL rmid_quiet c=%0d got=%b exp=000", c, {done, acc_valid, busy});
      end
    end
    start_pass(3, 1);
    for (int k = 1; k <= 8; k++) begin
      conv_valid_in = 1'b1; conv_data_in = DATA_W'(400 + k);
      step();
      got = {acc_valid, acc_data, acc_pixel_idx, acc_is_first, acc_is_last};
      exp = {1'b1, DATA_W'(400 + k), PIX_W'((k - 1) % 4), (k <= 4), (k >= 5)};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rmid_rerun k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    conv_valid_in = 1'b0;
    step();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL rmid_done got=%b exp=1", done);
    end
    step();
  endtask

  task automatic test_start_busy();
    logic [VW-1:0] got, exp;
    start_pass(3, 1);
    for (int k = 1; k <= 8; k++) begin
      conv_valid_in = 1'b1; conv_data_in = DATA_W'(500 + k);
      if (k == 3) begin
        cfg_last_pixel = '0; cfg_last_tile = '0; start = 1'b1;
      end
      step();
      start = 1'b0;
      got = {acc_valid, acc_data, acc_pixel_idx, acc_is_first, acc_is_last};
      exp = {1'b1, DATA_W'(500 + k), PIX_W'((k - 1) % 4), (k <= 4), (k >= 5)};
      n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL sbusy_beat k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    conv_valid_in = 1'b0;
    step();
    n_tests++;
    if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL sbusy_done got=%b exp=10", {done, busy});
    end
    repeat (3) step();
`ifdef ACC_SEQ_ERR_FLAG_EN
    n_tests++;
    if (err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sbusy_err_set got=%b exp=1", err_sticky);
    end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`ifdef ACC_SEQ_ERR_FLAG_EN
    n_tests++;
    if (err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL sbusy_err_clr got=%b exp=0", err_sticky);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_row4();
    test_width1();
    test_one_tile();
    test_gapped();
    test_reset_mid();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_tag_sequencer.md
Name: accum_tag_sequencer

Overview:
- Upstream driver for the partial-sum accumulator. Accepts the raw convolution result stream for one output row and one output channel.
- Tags each beat with pixel_idx, is_first_channel and is_last_channel while walking pixels (inner loop) and input-channel tiles (outer loop).
- Enforces the accumulator's read-modify-write spacing rule.
- Sits between the conv MAC array output and the accumulator; controlled by the layer controller via start/done.

Parameters:
- MAX_WIDTH, 512, max pixels per row; PIX_W = $clog2(MAX_WIDTH).
- MAX_CH_TILES, 64, max input-channel tiles per pass; TILE_W = $clog2(MAX_CH_TILES).
- DATA_W, 32, conv/accumulator data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_last_pixel  in  PIX_W  row width minus 1; sampled on accepted start
- cfg_last_tile  in  TILE_W  tile count minus 1; sampled on accepted start
- start  in  1  one-cycle request to begin a pass
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at pass completion
- conv_data_in  in  DATA_W  conv result
- conv_valid_in  in  1  conv beat present
- conv_ready_out  out  1  beat accepted when valid&&ready
- acc_data  out  DATA_W  to accumulator conv_data_in
- acc_valid  out  1  to accumulator conv_valid_in
- acc_is_first  out  1  to is_first_channel
- acc_is_last  out  1  to is_last_channel
- acc_pixel_idx  out  PIX_W  to pixel_idx

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; config registers 0. Reset mid-pass aborts immediately. No done is issued; no further acc_valid.
- FSM states:
  - IDLE: on start, latch cfg, clear pix_cnt/tile_cnt, go to RUN. busy rises the next cycle.
  - RUN: conv_ready_out=1 except during a hazard bubble. Each accepted beat advances the counters. On acceptance of the beat with pix_cnt==cfg_last_pixel and tile_cnt==cfg_last_tile, go to FLUSH.
  - FLUSH: conv_ready_out=0. Go to DONE after one cycle.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Start while not IDLE is ignored.
- Outputs are registered; latency is 1 cycle. An accepted beat at edge N appears on acc_* during cycle N+1.
- acc_valid is 0 on every cycle without an acceptance in the previous cycle. acc_data, acc_is_first, acc_is_last and acc_pixel_idx hold their previous values when acc_valid=0.
- Tags per beat:
  - acc_pixel_idx = pix_cnt.
  - acc_is_first = (tile_cnt==0).
  - acc_is_last = (tile_cnt==cfg_last_tile).
  - cfg_last_tile==0 gives first=last=1 on every beat.
- Counters:
  - pix_cnt wraps to 0 after cfg_last_pixel.
  - tile_cnt increments only on that wrap.
  - Unsigned, no saturation.
- Hazard rule: the accumulator needs at least one cycle between beats to the same pixel_idx. When cfg_last_pixel==0 (width 1), conv_ready_out drops for exactly one cycle after each accepted beat. Issue rate is therefore at most 1 beat per 2 cycles. Width>=2 runs at 1 beat/cycle.
- No back-pressure from the accumulator; acc_* are never stalled.
- conv_valid_in while IDLE, FLUSH or DONE is not accepted (ready=0).
- The done cycle follows the last acc_valid cycle directly.
- Start rejection: start is rejected, staying in IDLE, if cfg_last_tile > MAX_CH_TILES-1 when MAX_CH_TILES is not a power of two.

Optional Feature:
- Macro ACC_SEQ_ERR_FLAG_EN.
- Defined: adds output port err_sticky (1 bit). It is set by any of:
  - start while busy
  - a rejected start
  - conv_valid_in high in IDLE
  
  Cleared only by rst.
- Not defined: port and logic absent; those events are silently ignored as above.

Decomposition:
- Package accum_seq_pkg holds:
  - state enum {IDLE, RUN, FLUSH, DONE}
  - PIX_W and TILE_W width helper functions
  - the hazard bubble length constant (1)
- One natural sub-module, accum_seq_counter: nested pixel/tile counter with wrap and last flags, reused by the output writer.

Test Plan:
- Width 4, 3 tiles, continuous valid, data 1..12 -> 12 acc_valid beats:
  - idx 0,1,2,3 repeating
  - first=1 on beats 1-4, last=1 on beats 9-12
  - data unchanged
  - done one cycle after beat 12; busy low the same cycle.
- Width 1, 4 tiles -> conv_ready_out toggles 1,0,1,0. acc_valid never on consecutive cycles; idx always 0; last only on the 4th beat.
- 1 tile, width 3 -> every beat has first=1 and last=1; done after the 3rd beat.
- Gapped conv_valid_in (1 every 3 cycles), width 2, 2 tiles -> tags identical to the continuous case; acc_valid mirrors gaps delayed 1 cycle.
- rst asserted after 5 of 8 beats -> all outputs 0 next cycle, no done. A new start afterwards runs a full pass from idx 0, first=1.
- start pulsed while busy -> ignored, counters unaffected. With ACC_SEQ_ERR_FLAG_EN: err_sticky=1 and stays 1 until rst.
